// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: neuron FSM states and the defaults
// common to the synapse activation bus and the LIF neuron.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } lif_state_e;

    localparam int SNN_WIDTH              = 8;
    localparam int SNN_DEF_THRESHOLD      = 200;
    localparam int SNN_DEF_LEAK_SHIFT     = 3;
    localparam int SNN_DEF_REFRACT_CYCLES = 4;
    localparam int SNN_REFRACT_CNT_W      = 8;

endpackage

// File: rtl/lif_leak_add.sv
// Combinational membrane update: subtract the shift-based leak, add the
// synaptic activation, and clamp at full scale so the potential never wraps.
module lif_leak_add
    import snn_pkg::*;
#(
    parameter int WIDTH      = SNN_WIDTH,
    parameter int LEAK_SHIFT = SNN_DEF_LEAK_SHIFT
) (
    input  logic [WIDTH-1:0] membrane,
    input  logic [WIDTH-1:0] activation,
    output logic [WIDTH-1:0] v_next
);

    function automatic logic [WIDTH-1:0] sat_width(input logic [WIDTH:0] val);
        return val[WIDTH] ? {WIDTH{1'b1}} : val[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum_ext;

    // Leak is subtracted first, so the extra bit only ever carries overflow.
    always_comb begin
        leak    = membrane >> LEAK_SHIFT;
        sum_ext = {1'b0, membrane} - {1'b0, leak} + {1'b0, activation};
        v_next  = sat_width(sum_ext);
    end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates synaptic activation, fires a
// one-cycle spike on crossing threshold, then holds off for a refractory period.
module lif_neuron
    import snn_pkg::*;
#(
    parameter int WIDTH          = SNN_WIDTH,
    parameter int THRESHOLD      = SNN_DEF_THRESHOLD,
    parameter int LEAK_SHIFT     = SNN_DEF_LEAK_SHIFT,
    parameter int REFRACT_CYCLES = SNN_DEF_REFRACT_CYCLES,
    parameter int RESET_POT      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] activation,
    output logic             spike,
    output logic             refractory,
    output logic [WIDTH-1:0] membrane
);

    localparam int CNT_W = SNN_REFRACT_CNT_W;
    localparam logic [WIDTH-1:0] RESET_POT_V = WIDTH'(RESET_POT);
    localparam logic [WIDTH-1:0] THRESHOLD_V = WIDTH'(THRESHOLD);
    localparam logic [CNT_W-1:0] REFRACT_V   = CNT_W'(REFRACT_CYCLES);

    lif_state_e       state_q, state_d;
    logic [WIDTH-1:0] membrane_q, membrane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spike_q, spike_d;
    logic             refractory_q, refractory_d;
    logic [WIDTH-1:0] v_next;

    lif_leak_add #(
        .WIDTH      (WIDTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_leak_add (
        .membrane   (membrane_q),
        .activation (activation),
        .v_next     (v_next)
    );

    always_comb begin
        state_d    = state_q;
        membrane_d = membrane_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (enable) begin
                    membrane_d = v_next;
                    if (v_next >= THRESHOLD_V) state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                membrane_d = RESET_POT_V;
                cnt_d      = REFRACT_V;
                state_d    = (REFRACT_V != '0) ? ST_REFRACT : ST_INTEGRATE;
            end
            ST_REFRACT: begin
                membrane_d = RESET_POT_V;
                cnt_d      = cnt_q - CNT_W'(1);
                // The count was loaded with the full period, so leaving at 1 gives exactly that many cycles.
                if (cnt_q <= CNT_W'(1)) state_d = ST_INTEGRATE;
            end
            default: begin
                state_d = ST_INTEGRATE;
            end
        endcase
        spike_d      = (state_d == ST_FIRE);
        refractory_d = (state_d == ST_REFRACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INTEGRATE;
            membrane_q   <= '0;
            cnt_q        <= '0;
            spike_q      <= 1'b0;
            refractory_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            membrane_q   <= membrane_d;
            cnt_q        <= cnt_d;
            spike_q      <= spike_d;
            refractory_q <= refractory_d;
        end
    end

    assign spike      = spike_q;
    assign refractory = refractory_q;
    assign membrane   = membrane_q;

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron that consumes the 8-bit `activation` produced by a synapse and emits the single-cycle spike fed back to the synapse's `post_spike` input. It closes the synapse loop: the synapse weights pre-synaptic spikes into activation, and this block integrates that activation into a membrane potential. The membrane leaks each cycle, and the block fires on crossing a threshold, then enforces a refractory period.

Parameters:
WIDTH, 8, membrane and activation width in bits
THRESHOLD, 200, firing threshold; legal range 1..2^WIDTH-1
LEAK_SHIFT, 3, leak per integrate cycle = membrane >> LEAK_SHIFT; legal range 1..WIDTH-1
REFRACT_CYCLES, 4, cycles spent in REFRACT after a spike; legal range 0..255
RESET_POT, 0, membrane value loaded on fire and held during REFRACT; must be < THRESHOLD

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  gates integration in INTEGRATE state only
activation  input  WIDTH  synaptic drive, sampled every rising edge in INTEGRATE while enable=1
spike  output  1  registered; high for exactly one cycle per firing; drives synapse post_spike
refractory  output  1  registered; high while in REFRACT
membrane  output  WIDTH  registered current membrane potential (observability)

Behaviour:
- Reset values: state=INTEGRATE, membrane=0, spike=0, refractory=0, refractory counter=0.
- Asserting reset mid-operation, including during FIRE or REFRACT, aborts the operation and returns the block to the reset values. There is no pending spike after deassertion.
- Three-state FSM: INTEGRATE, FIRE, REFRACT. `spike` = (state==FIRE) and `refractory` = (state==REFRACT), both flop outputs.
- INTEGRATE with enable=1:
  - v_next = min(membrane - (membrane >> LEAK_SHIFT) + activation, 2^WIDTH-1).
  - Compute in WIDTH+1 bits, subtract leak first, then saturate.
  - If v_next >= THRESHOLD, then membrane <= v_next and state <= FIRE. Otherwise membrane <= v_next and the state stays INTEGRATE.
- INTEGRATE with enable=0: membrane and state hold. There is no leak and no integration.
- FIRE lasts exactly 1 cycle, independent of enable.
  - On exit, membrane <= RESET_POT and counter <= REFRACT_CYCLES.
  - The next state is REFRACT if REFRACT_CYCLES>0, else INTEGRATE.
  - Activation is ignored during FIRE.
- REFRACT, independent of enable:
  - Activation is ignored and membrane is held at RESET_POT.
  - The counter decrements each cycle. When counter==1 at a rising edge, state <= INTEGRATE.
  - REFRACT therefore lasts exactly REFRACT_CYCLES cycles.
- Latency: when activation sampled at edge N makes v_next cross the threshold, spike is high from edge N to edge N+1.
- Minimum spike period is REFRACT_CYCLES+2 cycles: 1 FIRE, REFRACT_CYCLES REFRACT, and 1 INTEGRATE sample. With defaults that is 6.
- Leak floor: membrane < 2^LEAK_SHIFT does not decay when activation=0. This is intended and is not a defect.
- Saturation: membrane never wraps. A saturated value of 2^WIDTH-1 always fires, because THRESHOLD <= 2^WIDTH-1.

Decomposition:
- Shared package `snn_pkg` holds:
  - the state enum (INTEGRATE/FIRE/REFRACT);
  - the WIDTH constant (8) shared with the synapse activation bus;
  - the default THRESHOLD, LEAK_SHIFT and REFRACT_CYCLES constants.
- One natural sub-module, `lif_leak_add`: combinational leak-subtract, add and saturate datapath. Its inputs are membrane and activation; its output is v_next. It is reusable by future neuron variants.
- The FSM and the refractory counter stay in lif_neuron.

Test Plan:
1. Reset asserted asynchronously mid-cycle while in REFRACT (after one spike) -> spike=0, refractory=0, membrane=0 immediately, before the next clk edge; state returns to INTEGRATE.
2. Defaults, membrane=0, enable=1, activation=50 constant -> membrane follows 50, 94, 133, 167, 197 after edges 1..5. After edge 6, membrane=223 and spike=1 for one cycle. After edge 7, spike=0, membrane=0, refractory=1 for 4 cycles.
3. Defaults, activation=255 constant -> spike period exactly 6 cycles. Spike high on cycles t, t+6, t+12. Refractory high on t+1..t+4.
4. Membrane=100 (via activation pulse 100 then activation=0) -> membrane decays 88, 77, 68, 60, 53 on successive edges. It stops decaying once below 8 (e.g. 7 holds at 7).
5. Integrate to membrane=133, then enable=0 for 10 cycles with activation=255 -> membrane holds 133 and spike stays 0. Re-enable with activation=50 -> integration resumes from 133.
6. REFRACT_CYCLES=0, activation=255 constant -> FIRE goes directly to INTEGRATE. Spike high every 2nd cycle and refractory never asserts. Activation=255 during FIRE/REFRACT in the default config has no effect on membrane (stays 0).
